fnd_view_ctrl: RTL and testbench

Display-view controller sitting between the stopwatch/watch cores and the FND controller. It arbitrates view-change requests from board buttons and the UART command decoder, then selects which 24-bit time word (stopwatch or watch) is displayed and in which view (msec:sec, min:hour, sec:min). It also supports freezing the displayed word and auto-returns to the default view after an inactivity timeout. Its outputs drive the FND controller's data input and view-select inputs.

---
 rtl/fnd_view_ctrl_if.sv | 16 +
 rtl/fnd_view_ctrl.sv | 153 +++++++++++++++
 tb/tb_fnd_view_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fnd_view_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fnd_view_ctrl_if
// Brief    : UART command handshake between the command decoder and the
//            display-view controller.
// Revision : 1.0
// ============================================================================
interface fnd_view_ctrl_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/fnd_view_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fnd_view_ctrl
// Brief    : Arbitrates button/UART view requests and selects the time word
//            and view shown on the FND, with freeze and idle auto-return.
// Revision : 1.0
// ============================================================================
module fnd_view_ctrl #(
    parameter int TICK_DIV      = 100_000,
    parameter int TIMEOUT_TICKS = 5000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [23:0] i_sw_data,
    input  wire logic [23:0] i_wt_data,
    input  wire logic        btn_view,
    input  wire logic        btn_src,
    input  wire logic        btn_freeze,
    fnd_view_ctrl_if.slave   cmd_if,
    output logic [23:0]      o_fnd_data,
    output logic [1:0]       o_view,
    output logic             o_src,
    output logic             o_frozen,
    output logic             o_cmd_err
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [PW-1:0] C_PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] C_IDLE_MAX  = IW'(TIMEOUT_TICKS);

    localparam logic [0:0] C_ST_LIVE   = 1'b0;
    localparam logic [0:0] C_ST_FROZEN = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [1:0]    view_q, view_d;
    logic          src_q, src_d;
    logic [23:0]   fnd_q, fnd_d;
    logic          err_q, err_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idle_q, idle_d;

    logic w_btn_any, w_cmd_acc, w_event, w_tick, w_timeout;
    logic w_is_v, w_is_s, w_is_f, w_is_r, w_is_unk;
    logic w_ev_view, w_ev_src, w_ev_frz, w_ev_rst;
    logic [23:0] w_sel_new;

    // Buttons always win the handshake; a blocked command simply stays pending.
    assign w_btn_any        = btn_view | btn_src | btn_freeze;
    assign cmd_if.cmd_ready = ~w_btn_any & ~reset;
    assign w_cmd_acc        = cmd_if.cmd_valid & cmd_if.cmd_ready;
    assign w_event          = w_btn_any | w_cmd_acc;

    always_comb begin
        w_is_v   = 1'b0;
        w_is_s   = 1'b0;
        w_is_f   = 1'b0;
        w_is_r   = 1'b0;
        w_is_unk = 1'b0;
        case (cmd_if.cmd_data)
            8'h56, 8'h76: w_is_v   = 1'b1;
            8'h53, 8'h73: w_is_s   = 1'b1;
            8'h46, 8'h66: w_is_f   = 1'b1;
            8'h52, 8'h72: w_is_r   = 1'b1;
            default:      w_is_unk = 1'b1;
        endcase
    end

    assign w_ev_view = btn_view   | (w_cmd_acc & w_is_v);
    assign w_ev_src  = btn_src    | (w_cmd_acc & w_is_s);
    assign w_ev_frz  = btn_freeze | (w_cmd_acc & w_is_f);
    assign w_ev_rst  = w_cmd_acc & w_is_r;

    assign w_tick    = ~w_event & (presc_q == C_PRESC_MAX);
    assign w_timeout = ~w_event & (state_q == C_ST_LIVE) & (view_q != 2'd0)
                       & (idle_q == C_IDLE_MAX);

    always_comb begin
        presc_d = presc_q;
        idle_d  = idle_q;
        if (w_event) begin
            presc_d = '0;
            idle_d  = '0;
        end else begin
            presc_d = w_tick ? '0 : presc_q + 1'b1;
            if (w_timeout)
                idle_d = '0;
            else if (w_tick && idle_q < C_IDLE_MAX)
                idle_d = idle_q + 1'b1;
        end
    end

    always_comb begin
        src_d  = w_ev_rst ? 1'b0 : (src_q ^ w_ev_src);
        view_d = view_q;
        if (w_ev_rst || w_timeout)
            view_d = 2'd0;
        else if (w_ev_view)
            view_d = (view_q == 2'd2) ? 2'd0 : view_q + 2'd1;
    end

    // Selection uses the post-toggle source so a same-cycle toggle is honoured.
    assign w_sel_new = src_d ? i_wt_data : i_sw_data;

    always_comb begin
        state_d = state_q;
        fnd_d   = fnd_q;
        err_d   = w_cmd_acc & w_is_unk;
        if (w_ev_rst) begin
            state_d = C_ST_LIVE;
            fnd_d   = i_sw_data;
        end else if (state_q == C_ST_LIVE) begin
            fnd_d = w_sel_new;
            if (w_ev_frz)
                state_d = C_ST_FROZEN;
        end else begin
            if (w_ev_frz) begin
                state_d = C_ST_LIVE;
                fnd_d   = w_sel_new;
            end else if (w_ev_src) begin
                fnd_d = w_sel_new;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= C_ST_LIVE;
            view_q  <= 2'd0;
            src_q   <= 1'b0;
            fnd_q   <= '0;
            err_q   <= 1'b0;
            presc_q <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            view_q  <= view_d;
            src_q   <= src_d;
            fnd_q   <= fnd_d;
            err_q   <= err_d;
            presc_q <= presc_d;
            idle_q  <= idle_d;
        end
    end

    assign o_fnd_data = fnd_q;
    assign o_view     = view_q;
    assign o_src      = src_q;
    assign o_frozen   = (state_q == C_ST_FROZEN);
    assign o_cmd_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fnd_view_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fnd_view_ctrl
// Brief    : Directed vector table plus multi-cycle sequences for fnd_view_ctrl.
// Revision : 1.0
// ============================================================================
module tb_fnd_view_ctrl;

    logic        clk;
    logic        reset;
    logic [23:0] i_sw_data, i_wt_data;
    logic        btn_view, btn_src, btn_freeze;
    logic [23:0] o_fnd_data;
    logic [1:0]  o_view;
    logic        o_src, o_frozen, o_cmd_err;

    int n_total = 0;
    int n_pass  = 0;

    fnd_view_ctrl_if cmd_if ();

    fnd_view_ctrl #(.TICK_DIV(4), .TIMEOUT_TICKS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_sw_data  (i_sw_data),
        .i_wt_data  (i_wt_data),
        .btn_view   (btn_view),
        .btn_src    (btn_src),
        .btn_freeze (btn_freeze),
        .cmd_if     (cmd_if),
        .o_fnd_data (o_fnd_data),
        .o_view     (o_view),
        .o_src      (o_src),
        .o_frozen   (o_frozen),
        .o_cmd_err  (o_cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        bv, bs, bf, cv;
        logic [7:0]  cd;
        logic [23:0] sw, wt;
        logic        rdy;
        logic [1:0]  view;
        logic        src, frz, err;
        logic [23:0] fnd;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [1:0] v, input logic s,
                               input logic f, input logic [23:0] d);
        check({tag, "_view"},   32'(o_view),     32'(v));
        check({tag, "_src"},    32'(o_src),      32'(s));
        check({tag, "_frozen"}, 32'(o_frozen),   32'(f));
        check({tag, "_fnd"},    32'(o_fnd_data), 32'(d));
    endtask

    initial begin
        //            bv    bs    bf    cv    cd     sw          wt          rdy   view  src   frz   err   fnd
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h000011, 24'hA00000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 24'h000011};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 24'h000022, 24'hA00000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 24'h000022};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h000033, 24'hA00000, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 24'h000033};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 24'h000044, 24'hA00000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 24'h000044};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h000055, 24'hA00000, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 24'h000055};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 24'h000066, 24'hA00000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 24'h000066};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h000077, 24'hA00000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 24'h000077};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h76, 24'h000088, 24'h123456, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 24'h123456};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h76, 24'h000099, 24'h123456, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 24'h123456};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h46, 24'h0000AA, 24'h123456, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 24'h123456};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h0000BB, 24'h000001, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 24'h123456};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h0000CC, 24'h000002, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 24'h123456};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 24'h0ABCDE, 24'h000003, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 24'h0ABCDE};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h0FFFFF, 24'h000004, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 24'h0ABCDE};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h78, 24'h0FFFFE, 24'h000005, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 24'h0ABCDE};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h0FFFFD, 24'h000006, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 24'h0ABCDE};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h72, 24'h0A0A0A, 24'h000007, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 24'h0A0A0A};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h010203, 24'h000008, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 24'h010203};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 24'h111111, 24'h222222, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 24'h222222};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h111111, 24'h333333, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 24'h222222};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h66, 24'h111111, 24'h333333, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 24'h333333};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h73, 24'h444444, 24'h333333, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 24'h444444};

        reset = 1'b0;
        btn_view = 1'b0; btn_src = 1'b0; btn_freeze = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_data = 8'h00;
        i_sw_data = 24'h0; i_wt_data = 24'h0;
        #2 reset = 1'b1;
        #1;
        check_state("reset", 2'd0, 1'b0, 1'b0, 24'h0);
        check("reset_err",   32'(o_cmd_err),        32'd0);
        check("reset_ready", 32'(cmd_if.cmd_ready), 32'd0);
        step();
        step();
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            btn_view = vecs[i].bv; btn_src = vecs[i].bs; btn_freeze = vecs[i].bf;
            cmd_if.cmd_valid = vecs[i].cv; cmd_if.cmd_data = vecs[i].cd;
            i_sw_data = vecs[i].sw; i_wt_data = vecs[i].wt;
            #1;
            check($sformatf("v%0d_ready", i), 32'(cmd_if.cmd_ready), 32'(vecs[i].rdy));
            step();
            check_state($sformatf("v%0d", i), vecs[i].view, vecs[i].src, vecs[i].frz, vecs[i].fnd);
            check($sformatf("v%0d_err", i), 32'(o_cmd_err), 32'(vecs[i].err));
        end
        btn_view = 1'b0; btn_src = 1'b0; btn_freeze = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_data = 8'h00;

        // Idle return from view 2: still 2 after 12 edges, 0 after 13.
        btn_view = 1'b1; step(); btn_view = 1'b0;
        check("to_view2", 32'(o_view), 32'd2);
        for (int k = 0; k < 12; k++) step();
        check("to_hold12", 32'(o_view), 32'd2);
        step();
        check("to_return", 32'(o_view), 32'd0);

        // An event on the timeout cycle cancels the return.
        btn_view = 1'b1; step(); btn_view = 1'b0;
        for (int k = 0; k < 12; k++) step();
        btn_src = 1'b1; step(); btn_src = 1'b0;
        check("tc_view_kept", 32'(o_view), 32'd1);
        check("tc_src",       32'(o_src),  32'd1);
        for (int k = 0; k < 12; k++) step();
        check("tc_hold12", 32'(o_view), 32'd1);
        step();
        check("tc_return", 32'(o_view), 32'd0);

        // No idle return while frozen; the unfreeze event restarts the count.
        btn_view = 1'b1; btn_freeze = 1'b1; step();
        btn_view = 1'b0; btn_freeze = 1'b0;
        for (int k = 0; k < 20; k++) step();
        check("fz_view", 32'(o_view),   32'd1);
        check("fz_frz",  32'(o_frozen), 32'd1);
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_data = 8'h46;
        step();
        cmd_if.cmd_valid = 1'b0;
        check("fz_unfreeze", 32'(o_frozen), 32'd0);
        for (int k = 0; k < 12; k++) step();
        check("fz_hold12", 32'(o_view), 32'd1);
        step();
        check("fz_return", 32'(o_view), 32'd0);

        // Reset mid-freeze with a command pending.
        i_sw_data = 24'h0C0C0C;
        btn_freeze = 1'b1; step(); btn_freeze = 1'b0;
        check("rm_frozen", 32'(o_frozen), 32'd1);
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_data = 8'h76;
        reset = 1'b1;
        #1;
        check_state("rm_async", 2'd0, 1'b0, 1'b0, 24'h0);
        check("rm_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
        step();
        step();
        check_state("rm_held", 2'd0, 1'b0, 1'b0, 24'h0);
        reset = 1'b0;
        #1;
        check("rm_ready_rel", 32'(cmd_if.cmd_ready), 32'd1);
        step();
        cmd_if.cmd_valid = 1'b0;
        check_state("rm_accept", 2'd1, 1'b0, 1'b0, 24'h0C0C0C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
